// File: rtl/axis_traffic_generator.sv
// AXI4-Stream master producing a deterministic counter or Galois-LFSR payload stream.
// Packets are PacketLength beats long; tid counts packets; every beat is registered.
module axis_traffic_generator #(
  parameter int unsigned              TDataWidth   = 32,
  parameter int unsigned              TidWidth     = 8,
  parameter int unsigned              TdestWidth   = 8,
  parameter int unsigned              PacketLength = 4,
  parameter int unsigned              DataMode     = 0,
  parameter logic [TDataWidth-1:0]    DataSeed     = '0,
  parameter logic [31:0]              LfsrTaps     = 32'h8020_0003,
  parameter logic [TdestWidth-1:0]    TdestValue   = '0
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_arst,
  input  logic                  tb_ena,
  output logic [TidWidth-1:0]   m_axis_tid,
  output logic [TdestWidth-1:0] m_axis_tdest,
  output logic [TDataWidth-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [31:0]           tx_count
);

  localparam int unsigned           BeatW     = (PacketLength > 1) ? $clog2(PacketLength) : 1;
  localparam logic [BeatW-1:0]      LastBeat  = BeatW'(PacketLength - 1);
  localparam logic [TDataWidth-1:0] Taps      = TDataWidth'(LfsrTaps);
  // An all-zero LFSR state would lock up, so the LFSR starts from 1 instead.
  localparam logic [TDataWidth-1:0] ResetData =
    (DataMode == 1 && DataSeed == '0) ? TDataWidth'(1) : DataSeed;
  localparam logic                  ResetLast = (PacketLength == 1);

  logic                  tvalid_q, tvalid_d;
  logic [TDataWidth-1:0] tdata_q, tdata_d;
  logic [BeatW-1:0]      beat_q, beat_d;
  logic                  tlast_q, tlast_d;
  logic [TidWidth-1:0]   tid_q, tid_d;
  logic [31:0]           tx_count_q, tx_count_d;
  logic [TDataWidth-1:0] next_data;

  always_comb begin
    if (DataMode == 1) begin
      next_data = tdata_q[0] ? ((tdata_q >> 1) ^ Taps) : (tdata_q >> 1);
    end else begin
      next_data = tdata_q + TDataWidth'(1);
    end
  end

  always_comb begin
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    beat_d     = beat_q;
    tid_d      = tid_q;
    tx_count_d = tx_count_q;
    if (tvalid_q && m_axis_tready) begin
      tdata_d    = next_data;
      tx_count_d = tx_count_q + 32'd1;
      tvalid_d   = tb_ena;
      if (beat_q == LastBeat) begin
        beat_d = '0;
        tid_d  = tid_q + TidWidth'(1);
      end else begin
        beat_d = beat_q + BeatW'(1);
      end
    end else if (!tvalid_q) begin
      tvalid_d = tb_ena;
    end
    // tlast is derived from the next index so it is registered alongside tdata.
    tlast_d = (beat_d == LastBeat);
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
    if (m_axis_arst) begin
      tvalid_q   <= 1'b0;
      tdata_q    <= ResetData;
      beat_q     <= '0;
      tlast_q    <= ResetLast;
      tid_q      <= '0;
      tx_count_q <= '0;
    end else begin
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      beat_q     <= beat_d;
      tlast_q    <= tlast_d;
      tid_q      <= tid_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;
  assign m_axis_tdest  = TdestValue;
  assign tx_count      = tx_count_q;

endmodule

// File: tb/tb_axis_traffic_generator.sv
// Directed bench for axis_traffic_generator: counter, LFSR and 8-bit wrap instances,
// with per-instance scoreboards popped on every observed transfer.
module tb_axis_traffic_generator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance 0: counter mode, defaults
  logic        ena0, rdy0, valid0, last0;
  logic [7:0]  tid0, tdest0;
  logic [31:0] data0, txc0;
  // Instance 1: LFSR mode, seed 0; instance 2: 8-bit counter, seed 0xFE (share ena1/rdy1)
  logic        ena1, rdy1, valid1, last1, valid2, last2;
  logic [7:0]  tid1, tdest1, tid2, tdest2, data2;
  logic [31:0] data1, txc1, txc2;

  axis_traffic_generator u0 (
    .m_axis_aclk(clk), .m_axis_arst(rst), .tb_ena(ena0),
    .m_axis_tid(tid0), .m_axis_tdest(tdest0), .m_axis_tdata(data0),
    .m_axis_tvalid(valid0), .m_axis_tlast(last0), .m_axis_tready(rdy0),
    .tx_count(txc0));

  axis_traffic_generator #(.DataMode(1), .TdestValue(8'h5A)) u1 (
    .m_axis_aclk(clk), .m_axis_arst(rst), .tb_ena(ena1),
    .m_axis_tid(tid1), .m_axis_tdest(tdest1), .m_axis_tdata(data1),
    .m_axis_tvalid(valid1), .m_axis_tlast(last1), .m_axis_tready(rdy1),
    .tx_count(txc1));

  axis_traffic_generator #(.TDataWidth(8), .DataSeed(8'hFE)) u2 (
    .m_axis_aclk(clk), .m_axis_arst(rst), .tb_ena(ena1),
    .m_axis_tid(tid2), .m_axis_tdest(tdest2), .m_axis_tdata(data2),
    .m_axis_tvalid(valid2), .m_axis_tlast(last2), .m_axis_tready(rdy1),
    .tx_count(txc2));

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  tid;
  } beat_t;

  beat_t       q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int          cnt0, cnt1, cnt2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] d, input logic l, input logic [7:0] t);
    beat_t b;
    b.data = d; b.last = l; b.tid = t;
    q0.push_back(b);
  endtask

  // Transfers are detected at the falling edge: valid && ready there means the beat
  // is accepted at the next rising edge, with the values currently on the bus.
  always @(negedge clk) begin
    if (rst) begin
      cnt0 = 0; cnt1 = 0; cnt2 = 0;
    end else begin
      if (valid0 && rdy0) begin
        check("u0_tx_count", txc0, 32'(cnt0));
        check("u0_beat_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          beat_t b;
          b = q0.pop_front();
          check("u0_tdata", data0, b.data);
          check("u0_tlast", 32'(last0), 32'(b.last));
          check("u0_tid", 32'(tid0), 32'(b.tid));
        end
        cnt0++;
      end
      if (valid1 && rdy1) begin
        check("u1_tx_count", txc1, 32'(cnt1));
        check("u1_beat_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) check("u1_lfsr_tdata", data1, q1.pop_front());
        cnt1++;
      end
      if (valid2 && rdy1) begin
        check("u2_tx_count", txc2, 32'(cnt2));
        check("u2_beat_expected", 32'(q2.size() != 0), 32'd1);
        if (q2.size() != 0) check("u2_wrap_tdata", 32'(data2), q2.pop_front());
        cnt2++;
      end
    end
  end

  initial begin
    rst = 1'b1; ena0 = 1'b0; rdy0 = 1'b0; ena1 = 1'b0; rdy1 = 1'b0;
    step(2);
    check("rst_tvalid", 32'(valid0), 32'd0);
    check("rst_tdata", data0, 32'd0);
    check("rst_tlast", 32'(last0), 32'd0);
    check("rst_tid", 32'(tid0), 32'd0);
    check("rst_txc", txc0, 32'd0);
    check("rst_tdest", 32'(tdest0), 32'd0);
    check("rst_lfsr_tdata", data1, 32'd1);
    check("rst_lfsr_tdest", 32'(tdest1), 32'h5A);
    check("rst_wrap_tdata", 32'(data2), 32'hFE);
    rst = 1'b0;
    step(1);

    // LFSR and 8-bit wrap instances: four accepted beats each
    q1.push_back(32'h0000_0001); q1.push_back(32'h8020_0003);
    q1.push_back(32'hC030_0002); q1.push_back(32'h6018_0001);
    q2.push_back(32'hFE); q2.push_back(32'hFF); q2.push_back(32'h00); q2.push_back(32'h01);
    ena1 = 1'b1; rdy1 = 1'b1;
    step(4);
    ena1 = 1'b0;
    step(2);
    check("lfsr_valid_off", 32'(valid1), 32'd0);
    check("lfsr_txc", txc1, 32'd4);
    check("lfsr_next", data1, 32'hB02C_0003);
    check("wrap_txc", txc2, 32'd4);
    check("wrap_next", 32'(data2), 32'h02);
    check("lfsr_q_empty", 32'(q1.size()), 32'd0);
    check("wrap_q_empty", 32'(q2.size()), 32'd0);

    // Free-running counter: 8 beats, tlast on 3 and 7, tid 0 then 1
    for (int i = 0; i < 8; i++) push0(32'(i), (i % 4) == 3, 8'(i / 4));
    ena0 = 1'b1; rdy0 = 1'b1;
    step(1);
    check("ena_to_valid", 32'(valid0), 32'd1);
    step(7);
    ena0 = 1'b0;
    step(3);
    check("free_valid_off", 32'(valid0), 32'd0);
    check("free_txc", txc0, 32'd8);
    check("free_next_data", data0, 32'd8);
    check("free_next_tid", 32'(tid0), 32'd2);
    check("free_next_last", 32'(last0), 32'd0);
    check("free_q_empty", 32'(q0.size()), 32'd0);

    // Backpressure: 5 stalled cycles, then two transfers
    rdy0 = 1'b0; ena0 = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("bp_tvalid", 32'(valid0), 32'd1);
      check("bp_tdata", data0, 32'd8);
      check("bp_tid", 32'(tid0), 32'd2);
      check("bp_tlast", 32'(last0), 32'd0);
      check("bp_txc", txc0, 32'd8);
    end
    push0(32'd8, 1'b0, 8'd2);
    push0(32'd9, 1'b0, 8'd2);
    rdy0 = 1'b1;
    step(1);
    ena0 = 1'b0;
    step(3);
    check("bp_valid_off", 32'(valid0), 32'd0);
    check("bp_txc_after", txc0, 32'd10);

    // Single-cycle enable pulse with tready low: the pending beat must survive
    rdy0 = 1'b0; ena0 = 1'b1;
    step(1);
    ena0 = 1'b0;
    step(3);
    check("pulse_valid_held", 32'(valid0), 32'd1);
    check("pulse_tdata", data0, 32'd10);
    push0(32'd10, 1'b0, 8'd2);
    rdy0 = 1'b1;
    step(1);
    step(2);
    check("pulse_valid_off", 32'(valid0), 32'd0);
    check("pulse_txc", txc0, 32'd11);
    check("pulse_q_empty", 32'(q0.size()), 32'd0);

    // Resume mid-packet, then asynchronous reset mid-stream
    push0(32'd11, 1'b1, 8'd2);
    push0(32'd12, 1'b0, 8'd3);
    ena0 = 1'b1; rdy0 = 1'b1;
    step(3);
    rst = 1'b1;
    #1;
    check("arst_tvalid", 32'(valid0), 32'd0);
    check("arst_tdata", data0, 32'd0);
    check("arst_txc", txc0, 32'd0);
    check("arst_tid", 32'(tid0), 32'd0);
    check("arst_tlast", 32'(last0), 32'd0);
    check("arst_q_empty", 32'(q0.size()), 32'd0);
    ena0 = 1'b0; rdy0 = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);

    // After reset the stream restarts from the seed with tid 0
    push0(32'd0, 1'b0, 8'd0);
    push0(32'd1, 1'b0, 8'd0);
    ena0 = 1'b1; rdy0 = 1'b1;
    step(2);
    ena0 = 1'b0;
    step(3);
    check("post_rst_txc", txc0, 32'd2);
    check("post_rst_valid_off", 32'(valid0), 32'd0);
    check("post_rst_q_empty", 32'(q0.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
